key_note_selector: RTL

- Sits directly downstream of the per-note tone generators. Each generator drives a free-running square wave, one per piano note.
- Debounces the raw piano key switches and picks one pressed key by priority. It then routes that key's square wave to the single buzzer/speaker pin.
- Switching between notes is glitch-free: a new selection takes effect only while the audio output is low.
- Reports the debounced key state and the active key code for LEDs/display.

---
 rtl/key_note_selector_if.sv | 23 ++
 rtl/key_note_selector.sv | 84 ++++++++
 2 files changed

// File: rtl/key_note_selector_if.sv
// Key/note bundle between the tone generators, key matrix and the selector.
// The selector takes the slave side; the board/testbench drives the master side.
interface key_note_selector_if #(
    parameter int NUM_KEYS = 8,
    parameter int KEY_W    = 3
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] note_in;
    logic                audio_out;
    logic                key_valid;
    logic [KEY_W-1:0]    key_code;
    logic [NUM_KEYS-1:0] key_stable;

    modport slave (
        input  key_in, note_in,
        output audio_out, key_valid, key_code, key_stable
    );

    modport master (
        output key_in, note_in,
        input  audio_out, key_valid, key_code, key_stable
    );
endinterface

// File: rtl/key_note_selector.sv
// Debounces piano keys, picks the highest pressed key and routes its tone to
// the speaker pin, switching notes only while the output is low.
module key_note_selector #(
    parameter int NUM_KEYS        = 8,
    parameter int KEY_W           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    key_note_selector_if.slave    bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0]            r_sync1;
    logic [NUM_KEYS-1:0]            r_sync2;
    logic [NUM_KEYS-1:0]            r_stable;
    logic [NUM_KEYS-1:0][CNT_W-1:0] r_cnt;
    logic                           r_act_valid;
    logic [KEY_W-1:0]               r_act_sel;
    logic                           r_audio;
    logic                           w_pend_valid;
    logic [KEY_W-1:0]               w_pend_sel;

    // Two-flop synchronizer for the asynchronous key switches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Any single agreeing cycle restarts the count, so short bounces never land.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_stable <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Highest pressed index wins.
    always_comb begin
        w_pend_sel = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (r_stable[i]) w_pend_sel = KEY_W'(i);
        end
    end

    assign w_pend_valid = |r_stable;

    // Selection may only move while the speaker is low, so high phases finish intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_act_valid <= 1'b0;
            r_act_sel   <= '0;
            r_audio     <= 1'b0;
        end else begin
            if (!r_audio) begin
                r_act_valid <= w_pend_valid;
                r_act_sel   <= w_pend_sel;
            end
            r_audio <= r_act_valid & bus.note_in[r_act_sel];
        end
    end

    assign bus.audio_out  = r_audio;
    assign bus.key_valid  = r_act_valid;
    assign bus.key_code   = r_act_valid ? r_act_sel : '0;
    assign bus.key_stable = r_stable;
endmodule
